// File: rtl/noc_mon_pkg.sv
// Shared definitions for the NoC traffic monitor.
//
// Holds the measurement FSM state encoding and the default widths used by
// the monitor, its link interface and the saturating counters.
package noc_mon_pkg;

   localparam int DEF_NUM_PE      = 4;
   localparam int DEF_DATA_WIDTH  = 32;
   localparam int DEF_COUNT_WIDTH = 32;

   // IDLE: waiting for a start. RUN: counting. DONE: target reached, counts frozen.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } mon_state_t;

endpackage

// File: rtl/noc_traffic_monitor_if.sv
// Observation bundle for the NoC-to-PE delivery links.
//
// Signals:
//   i_data       - flattened flits, port p at slice p, destination address in
//                  the MSBs of each flit above the payload
//   i_data_valid - per-port valid seen on the link
//   i_data_ready - per-port ready seen on the link
// Modports:
//   master - whoever drives the links (the NoC side, or a testbench)
//   slave  - a passive observer such as the traffic monitor
interface noc_mon_if
   import noc_mon_pkg::*;
#(
   parameter int NUMPE     = DEF_NUM_PE,
   parameter int AddrWidth = $clog2(NUMPE),
   parameter int DataWidth = DEF_DATA_WIDTH
);

   logic [NUMPE*(DataWidth+AddrWidth)-1:0] i_data;
   logic [NUMPE-1:0]                       i_data_valid;
   logic [NUMPE-1:0]                       i_data_ready;

   modport master (output i_data, i_data_valid, i_data_ready);
   modport slave  (input  i_data, i_data_valid, i_data_ready);

endinterface

// File: rtl/noc_mon_sat_counter.sv
// Saturating up-counter used for every statistic of the traffic monitor.
//
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   clear    - synchronous zeroing, same effect as rst
//   inc      - amount added this cycle (0 leaves the count unchanged)
//   count    - registered count, sticks at all-ones instead of wrapping
//   sat      - high in a cycle whose increment lands on or beyond all-ones,
//              i.e. the counter is saturated after this edge
module noc_mon_sat_counter #(
   parameter int Width    = 32,
   parameter int IncWidth = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic [IncWidth-1:0] inc,
   output logic [Width-1:0]    count,
   output logic                sat
);

   localparam int             SumW    = Width + 1;
   localparam logic [SumW-1:0] MaxWide = {1'b0, {Width{1'b1}}};

   logic [SumW-1:0]  sum_wide;
   logic [Width-1:0] count_d;

   // The add is done one bit wider so a carry out is seen and clamped
   // rather than wrapped.
   always_comb begin
      sum_wide = {1'b0, count} + SumW'(inc);
      sat      = (inc != '0) && (sum_wide >= MaxWide);
      count_d  = (sum_wide > MaxWide) ? {Width{1'b1}} : sum_wide[Width-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else begin
         count <= count_d;
      end
   end

endmodule

// File: rtl/noc_traffic_monitor.sv
// Passive traffic monitor for the NoC-to-PE delivery ports.
//
// A measurement starts on i_start, counts every accepted flit (valid and
// ready both high) per port, in total, and as misrouted when the flit's
// address field differs from the port it arrived on, and finishes once the
// total reaches the expected packet count latched at start.
//
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   i_start            - start a measurement (ignored while running)
//   i_clear            - abort and zero everything; beats i_start
//   i_expected         - packet target, latched when a start is accepted
//   link               - observed delivery links (slave modport)
//   o_busy             - measurement running
//   o_done             - target reached (level)
//   o_done_pulse       - first cycle of o_done only
//   o_total_count      - accepted packets, all ports
//   o_cycle_count      - cycles spent running
//   o_misroute_count   - accepted packets whose address did not match the port
//   o_port_count       - per-port accepted packets, port p at slice p
//   o_overflow         - sticky, some counter reached all-ones
module noc_traffic_monitor
   import noc_mon_pkg::*;
#(
   parameter int NUMPE      = DEF_NUM_PE,
   parameter int AddrWidth  = $clog2(NUMPE),
   parameter int DataWidth  = DEF_DATA_WIDTH,
   parameter int CountWidth = DEF_COUNT_WIDTH
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_start,
   input  logic                        i_clear,
   input  logic [CountWidth-1:0]       i_expected,
   noc_mon_if.slave                    link,
   output logic                        o_busy,
   output logic                        o_done,
   output logic                        o_done_pulse,
   output logic [CountWidth-1:0]       o_total_count,
   output logic [CountWidth-1:0]       o_cycle_count,
   output logic [CountWidth-1:0]       o_misroute_count,
   output logic [NUMPE*CountWidth-1:0] o_port_count,
   output logic                        o_overflow
);

   localparam int FlitWidth = DataWidth + AddrWidth;
   localparam int SumWidth  = $clog2(NUMPE + 1);
   localparam int TotW      = CountWidth + 1;

   mon_state_t state_q, state_d;

   logic                  start_accept;
   logic                  clear_counts;
   logic                  run_active;
   logic                  target_hit;
   logic [CountWidth-1:0] expected_q;
   logic [NUMPE-1:0]      accepted;
   logic [NUMPE-1:0]      misrouted;
   logic [SumWidth-1:0]   accepted_sum;
   logic [SumWidth-1:0]   misrouted_sum;
   logic [TotW-1:0]       total_wide;
   logic [NUMPE-1:0]      port_sat;
   logic                  total_sat;
   logic                  cycle_sat;
   logic                  misroute_sat;

   assign run_active   = (state_q == ST_RUN);
   assign clear_counts = i_clear | start_accept;

   // Packets only count while running; the misroute test compares each
   // flit's address field with the index of the port it was delivered on.
   always_comb begin
      accepted      = '0;
      misrouted     = '0;
      accepted_sum  = '0;
      misrouted_sum = '0;
      for (int p = 0; p < NUMPE; p++) begin
         accepted[p]   = run_active & link.i_data_valid[p] & link.i_data_ready[p];
         misrouted[p]  = accepted[p] &&
                         (link.i_data[p*FlitWidth+DataWidth +: AddrWidth] != AddrWidth'(p));
         accepted_sum  = accepted_sum + SumWidth'(accepted[p]);
         misrouted_sum = misrouted_sum + SumWidth'(misrouted[p]);
      end
   end

   // The target test uses the unclamped sum; clamping can only land on
   // all-ones, which is never below a CountWidth-bit target, so the result
   // matches a test on the saturated total and an overshoot still finishes.
   assign total_wide = {1'b0, o_total_count} + TotW'(accepted_sum);
   assign target_hit = (total_wide >= {1'b0, expected_q});

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state. Clear wins over everything else; a start is only taken
   // from IDLE or DONE, so a start pulse during RUN has no effect.
   always_comb begin
      state_d      = state_q;
      start_accept = 1'b0;
      if (i_clear) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (i_start) begin
                  start_accept = 1'b1;
                  state_d      = ST_RUN;
               end
            end
            ST_RUN: begin
               if (target_hit) begin
                  state_d = ST_DONE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Status flags are registered from the next state so they line up with
   // the counters that update on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_busy       <= 1'b0;
         o_done       <= 1'b0;
         o_done_pulse <= 1'b0;
      end else begin
         o_busy       <= (state_d == ST_RUN);
         o_done       <= (state_d == ST_DONE);
         o_done_pulse <= (state_d == ST_DONE) && (state_q != ST_DONE);
      end
   end

   // Target is captured only when a measurement actually starts.
   always_ff @(posedge clk) begin
      if (rst) begin
         expected_q <= '0;
      end else if (start_accept) begin
         expected_q <= i_expected;
      end
   end

   // Overflow is sticky for the whole measurement and only a new start,
   // a clear or reset drops it.
   always_ff @(posedge clk) begin
      if (rst || clear_counts) begin
         o_overflow <= 1'b0;
      end else if ((|port_sat) || total_sat || cycle_sat || misroute_sat) begin
         o_overflow <= 1'b1;
      end
   end

   for (genvar p = 0; p < NUMPE; p++) begin : g_port
      noc_mon_sat_counter #(
         .Width    (CountWidth),
         .IncWidth (1)
      ) u_port_cnt (
         .clk   (clk),
         .rst   (rst),
         .clear (clear_counts),
         .inc   (accepted[p]),
         .count (o_port_count[p*CountWidth +: CountWidth]),
         .sat   (port_sat[p])
      );
   end

   noc_mon_sat_counter #(
      .Width    (CountWidth),
      .IncWidth (SumWidth)
   ) u_total_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (clear_counts),
      .inc   (accepted_sum),
      .count (o_total_count),
      .sat   (total_sat)
   );

   noc_mon_sat_counter #(
      .Width    (CountWidth),
      .IncWidth (1)
   ) u_cycle_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (clear_counts),
      .inc   (run_active),
      .count (o_cycle_count),
      .sat   (cycle_sat)
   );

   noc_mon_sat_counter #(
      .Width    (CountWidth),
      .IncWidth (SumWidth)
   ) u_misroute_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (clear_counts),
      .inc   (misrouted_sum),
      .count (o_misroute_count),
      .sat   (misroute_sat)
   );

endmodule

// File: tb/tb_noc_traffic_monitor.sv
// Testbench for noc_traffic_monitor.
//
// Two monitors watch the same links and control inputs: one with 32-bit
// counters and one with 4-bit counters (its target is the low nibble of
// i_expected), so saturation is exercised alongside the normal behaviour.
// Each measurement's expected end state is computed up front from the
// per-cycle traffic and queued; a monitor process checks it when the DUT
// raises its done pulse, or when the stimulus asks for a snapshot.
module tb_noc_traffic_monitor;

   localparam int NP = 4;
   localparam int AW = 2;
   localparam int DW = 32;
   localparam int FW = DW + AW;

   typedef struct packed {
      logic             snap;
      logic [31:0]      total;
      logic [31:0]      cycles;
      logic [31:0]      misroute;
      logic [3:0][31:0] port;
      logic             overflow;
      logic             busy;
      logic             done;
   } result_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_start;
   logic        i_clear;
   logic [31:0] i_expected;
   logic        snap_req;

   logic         busy_b, done_b, pulse_b, overflow_b;
   logic [31:0]  total_b, cycle_b, mis_b;
   logic [127:0] port_b;
   logic         busy_s, done_s, pulse_s, overflow_s;
   logic [3:0]   total_s, cycle_s, mis_s;
   logic [15:0]  port_s;

   int n_checks = 0;
   int n_fail   = 0;

   result_t    exp_q0[$];
   result_t    exp_q1[$];
   logic [3:0] pat_v[$];
   logic [3:0] pat_r[$];
   logic [7:0] pat_a[$];

   always #5 clk = ~clk;

   noc_mon_if #(.NUMPE(NP), .AddrWidth(AW), .DataWidth(DW)) link ();

   noc_traffic_monitor #(
      .NUMPE(NP), .AddrWidth(AW), .DataWidth(DW), .CountWidth(32)
   ) dut_big (
      .clk(clk), .rst(rst), .i_start(i_start), .i_clear(i_clear),
      .i_expected(i_expected), .link(link),
      .o_busy(busy_b), .o_done(done_b), .o_done_pulse(pulse_b),
      .o_total_count(total_b), .o_cycle_count(cycle_b),
      .o_misroute_count(mis_b), .o_port_count(port_b), .o_overflow(overflow_b)
   );

   noc_traffic_monitor #(
      .NUMPE(NP), .AddrWidth(AW), .DataWidth(DW), .CountWidth(4)
   ) dut_small (
      .clk(clk), .rst(rst), .i_start(i_start), .i_clear(i_clear),
      .i_expected(i_expected[3:0]), .link(link),
      .o_busy(busy_s), .o_done(done_s), .o_done_pulse(pulse_s),
      .o_total_count(total_s), .o_cycle_count(cycle_s),
      .o_misroute_count(mis_s), .o_port_count(port_s), .o_overflow(overflow_s)
   );

   function automatic longint unsigned satAdd(input longint unsigned a,
                                              input longint unsigned b,
                                              input longint unsigned m);
      return (a + b > m) ? m : a + b;
   endfunction

   // Reference: replay the queued traffic one cycle at a time, counting
   // handshakes until the total reaches the target; counts stick at the
   // counter maximum, and overflow means some count ended at that maximum.
   function automatic result_t model(input logic [31:0] exp_in, input int width);
      result_t           r;
      longint unsigned   maxv = (64'd1 << width) - 1;
      longint unsigned   expv = longint'(exp_in) & maxv;
      longint unsigned   tot  = 0;
      longint unsigned   cyc  = 0;
      longint unsigned   mis  = 0;
      longint unsigned   pc[4];
      bit                fin  = 0;
      bit                ovf;
      for (int p = 0; p < NP; p++) pc[p] = 0;
      for (int c = 0; c < pat_v.size() && !fin; c++) begin
         int n = 0;
         cyc = satAdd(cyc, 1, maxv);
         for (int p = 0; p < NP; p++) begin
            if (pat_v[c][p] && pat_r[c][p]) begin
               n++;
               pc[p] = satAdd(pc[p], 1, maxv);
               if (int'(pat_a[c][2*p +: 2]) != p) mis = satAdd(mis, 1, maxv);
            end
         end
         tot = satAdd(tot, longint'(n), maxv);
         fin = (tot >= expv);
      end
      ovf = (tot == maxv) || (cyc == maxv) || (mis == maxv);
      r = '0;
      for (int p = 0; p < NP; p++) begin
         r.port[p] = 32'(pc[p]);
         if (pc[p] == maxv) ovf = 1;
      end
      r.snap     = !fin;
      r.total    = 32'(tot);
      r.cycles   = 32'(cyc);
      r.misroute = 32'(mis);
      r.overflow = ovf;
      r.busy     = !fin;
      r.done     = fin;
      return r;
   endfunction

   function automatic result_t idleRecord();
      result_t r;
      r      = '0;
      r.snap = 1'b1;
      return r;
   endfunction

   function automatic result_t observe(input int inst);
      result_t r;
      r = '0;
      if (inst == 0) begin
         r.total = total_b; r.cycles = cycle_b; r.misroute = mis_b;
         for (int p = 0; p < NP; p++) r.port[p] = port_b[p*32 +: 32];
         r.overflow = overflow_b; r.busy = busy_b; r.done = done_b;
      end else begin
         r.total = {28'd0, total_s}; r.cycles = {28'd0, cycle_s};
         r.misroute = {28'd0, mis_s};
         for (int p = 0; p < NP; p++) r.port[p] = {28'd0, port_s[p*4 +: 4]};
         r.overflow = overflow_s; r.busy = busy_s; r.done = done_s;
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] got,
                              input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   task automatic compareRecord(input string tag, input result_t got, input result_t want);
      checkOutput({tag, ".total"},    got.total,    want.total);
      checkOutput({tag, ".cycles"},   got.cycles,   want.cycles);
      checkOutput({tag, ".misroute"}, got.misroute, want.misroute);
      for (int p = 0; p < NP; p++)
         checkOutput($sformatf("%s.port%0d", tag, p), got.port[p], want.port[p]);
      checkOutput({tag, ".overflow"}, 32'(got.overflow), 32'(want.overflow));
      checkOutput({tag, ".busy"},     32'(got.busy),     32'(want.busy));
      checkOutput({tag, ".done"},     32'(got.done),     32'(want.done));
   endtask

   // Scoreboard side: a done pulse or a snapshot request consumes the
   // oldest expectation of that monitor instance.
   task automatic service(input int inst);
      result_t got, want;
      logic    pulse;
      bit      have;
      string   tag;
      tag   = (inst == 0) ? "big" : "small";
      got   = observe(inst);
      pulse = (inst == 0) ? pulse_b : pulse_s;
      have  = (inst == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
      if (pulse || snap_req) begin
         if (!have) begin
            if (pulse) begin
               n_checks++;
               n_fail++;
               $display("[TB] FAIL %s.done_pulse: got 1, want 0 (nothing pending)", tag);
            end
         end else begin
            want = (inst == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            checkOutput({tag, ".done_pulse"}, 32'(pulse), 32'(!want.snap));
            compareRecord(tag, got, want);
         end
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         service(0);
         service(1);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic driveLinks(input logic [3:0] v, input logic [3:0] r, input logic [7:0] a);
      link.i_data_valid = v;
      link.i_data_ready = r;
      for (int p = 0; p < NP; p++)
         link.i_data[p*FW +: FW] = {a[2*p +: 2], 32'($urandom())};
   endtask

   task automatic snapCheck();
      snap_req = 1'b1;
      @(negedge clk);
      #1;
      snap_req = 1'b0;
   endtask

   task automatic waitDrain();
      for (int i = 0; i < 40 && (exp_q0.size() > 0 || exp_q1.size() > 0); i++)
         @(negedge clk);
      #1;
      if (exp_q0.size() > 0 || exp_q1.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL drain_timeout: got %0d/%0d pending, want 0/0",
                  exp_q0.size(), exp_q1.size());
         exp_q0.delete();
         exp_q1.delete();
      end
   endtask

   task automatic fillPattern(input int n, input logic [3:0] v, input logic [3:0] r,
                              input logic [7:0] a);
      pat_v.delete(); pat_r.delete(); pat_a.delete();
      for (int c = 0; c < n; c++) begin
         pat_v.push_back(v); pat_r.push_back(r); pat_a.push_back(a);
      end
   endtask

   // One measurement: clear, start with the target, replay the queued
   // traffic, then take a snapshot for any instance still running.
   task automatic applyStimulus(input logic [31:0] expv);
      result_t eb, es;
      eb = model(expv, 32);
      es = model(expv, 4);
      exp_q0.push_back(eb);
      exp_q1.push_back(es);
      driveLinks(4'h0, 4'h0, 8'h00);
      i_clear = 1'b1;
      step();
      i_clear    = 1'b0;
      i_start    = 1'b1;
      i_expected = expv;
      step();
      i_start = 1'b0;
      for (int c = 0; c < pat_v.size(); c++) begin
         driveLinks(pat_v[c], pat_r[c], pat_a[c]);
         step();
      end
      driveLinks(4'h0, 4'h0, 8'h00);
      if (eb.snap || es.snap) snapCheck();
      waitDrain();
   endtask

   task automatic expectIdleSnap();
      exp_q0.push_back(idleRecord());
      exp_q1.push_back(idleRecord());
      snapCheck();
      waitDrain();
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no end of test, want end before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   localparam logic [7:0] ADDR_OK = 8'b11_10_01_00;

   initial begin
      logic [7:0] a;
      rst        = 1'b1;
      i_start    = 1'b0;
      i_clear    = 1'b0;
      i_expected = '0;
      snap_req   = 1'b0;
      driveLinks(4'h0, 4'h0, 8'h00);
      step();
      step();
      $display("[TB] reset state");
      expectIdleSnap();
      rst = 1'b0;
      step();

      $display("[TB] full load, target 400");
      fillPattern(100, 4'hF, 4'hF, ADDR_OK);
      applyStimulus(32'd400);

      $display("[TB] overshoot, target 5");
      fillPattern(4, 4'hF, 4'hF, ADDR_OK);
      applyStimulus(32'd5);

      $display("[TB] misrouted port 2");
      fillPattern(3, 4'b0100, 4'hF, 8'b11_01_01_00);
      applyStimulus(32'd1000);

      $display("[TB] valid without ready");
      fillPattern(10, 4'hF, 4'h0, ADDR_OK);
      applyStimulus(32'd1000);

      $display("[TB] saturation on port 0");
      fillPattern(20, 4'b0001, 4'b0001, ADDR_OK);
      applyStimulus(32'h10F);

      $display("[TB] zero target");
      fillPattern(3, 4'hF, 4'b1010, ADDR_OK);
      applyStimulus(32'd0);

      $display("[TB] clear mid-run with simultaneous start");
      driveLinks(4'h0, 4'h0, 8'h00);
      i_start    = 1'b1;
      i_expected = 32'h3EF;
      step();
      i_start = 1'b0;
      driveLinks(4'hF, 4'hF, ADDR_OK);
      step();
      step();
      i_clear = 1'b1;
      i_start = 1'b1;
      step();
      i_clear = 1'b0;
      i_start = 1'b0;
      driveLinks(4'h0, 4'h0, 8'h00);
      expectIdleSnap();
      step();
      expectIdleSnap();

      $display("[TB] reset mid-run");
      i_start    = 1'b1;
      i_expected = 32'h3EF;
      step();
      i_start = 1'b0;
      driveLinks(4'hF, 4'hF, ADDR_OK);
      step();
      step();
      rst = 1'b1;
      step();
      driveLinks(4'h0, 4'h0, 8'h00);
      expectIdleSnap();
      rst = 1'b0;
      step();

      $display("[TB] random traffic");
      for (int t = 0; t < 10; t++) begin
         int n;
         n = $urandom_range(1, 25);
         pat_v.delete(); pat_r.delete(); pat_a.delete();
         for (int c = 0; c < n; c++) begin
            a = ADDR_OK;
            for (int p = 0; p < NP; p++)
               if ($urandom_range(0, 3) == 0) a[2*p +: 2] = 2'($urandom_range(0, 3));
            pat_v.push_back(4'($urandom_range(0, 15)));
            pat_r.push_back(4'($urandom_range(0, 15)));
            pat_a.push_back(a);
         end
         applyStimulus(32'($urandom_range(0, 40)));
      end

      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/noc_traffic_monitor.md
NOC_TRAFFIC_MONITOR -- requirements
Module: noc_traffic_monitor

Interface
REQ-001 SHALL have parameter NUMPE, default 4, giving the number of monitored PE delivery ports.
REQ-002 SHALL have parameter AddrWidth, default $clog2(NUMPE), giving the width of the destination-address field.
REQ-003 SHALL have parameter DataWidth, default 32, giving the payload width; per-port flit width is DataWidth+AddrWidth, with the address in the MSBs.
REQ-004 SHALL have parameter CountWidth, default 32, giving the width of every counter.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port i_start, input, 1 bit: begin a measurement.
REQ-008 SHALL have port i_clear, input, 1 bit: abort the measurement and zero all counters.
REQ-009 SHALL have port i_expected, input, CountWidth bits: packet target, sampled when i_start is accepted.
REQ-010 SHALL have port i_data, input, NUMPE*(DataWidth+AddrWidth) bits: flattened delivered flits, with port p at slice p.
REQ-011 SHALL have ports i_data_valid and i_data_ready, input, NUMPE bits each: per-port handshake observed on the NoC-to-PE links.
REQ-012 SHALL have port o_busy, output, 1 bit: high while in state RUN.
REQ-013 SHALL have ports o_done (level) and o_done_pulse (one cycle), output, 1 bit each.
REQ-014 SHALL have ports o_total_count, o_cycle_count and o_misroute_count, output, CountWidth bits each.
REQ-015 SHALL have port o_port_count, output, NUMPE*CountWidth bits: per-port accepted-packet counts.
REQ-016 SHALL have port o_overflow, output, 1 bit: sticky flag, set when any counter saturates.

Function
REQ-017 SHALL implement FSM IDLE->RUN on i_start; RUN->DONE when the updated total >= the latched expected value; DONE->RUN on i_start; any state->IDLE on i_clear.
REQ-018 SHALL give i_clear priority over i_start in the same cycle; i_start SHALL be ignored while in RUN.
REQ-019 SHALL zero all counters and o_overflow, and latch i_expected, in the cycle i_start is accepted; the state SHALL be RUN from the next cycle.
REQ-020 SHALL count a packet on port p only in RUN and only when i_data_valid[p] and i_data_ready[p] are both high.
REQ-021 SHALL add 0..NUMPE accepted packets to o_total_count in one cycle; a total that overshoots the expected value SHALL still produce DONE.
REQ-022 SHALL increment o_misroute_count, per accepted packet, when the address field of port p is not equal to p.
REQ-023 SHALL increment o_cycle_count in every RUN cycle, including the cycle in which the DONE condition is met.
REQ-024 SHALL register all outputs; o_done_pulse SHALL be high for exactly the first DONE cycle.
REQ-025 SHALL saturate every counter at all-ones, with no wrap, and set o_overflow.
REQ-026 SHALL enter DONE on the first RUN cycle when the latched expected value is 0.
REQ-027 SHALL hold all counts stable in IDLE and DONE.

Reset
REQ-028 SHALL, when rst is high at a clk edge, force state IDLE and drive all outputs and counters to 0; rst SHALL override i_clear and i_start.
REQ-029 SHALL abandon any measurement in progress on a reset mid-RUN, with no done pulse.

Structure
REQ-030 SHALL place the FSM state encoding (IDLE/RUN/DONE) and the default-width constants in shared package noc_mon_pkg.
REQ-031 SHALL use one sub-module, noc_mon_sat_counter (clear, increment amount, saturate flag), instantiated for the per-port counters, the total, the cycle counter and the misroute counter.

Verification
REQ-032 SHALL verify: NUMPE=4, expected=400, all ports accept 1 packet/cycle -> DONE after 100 RUN cycles, total=400, each port=100, cycle=100, one o_done_pulse.
REQ-033 SHALL verify: expected=5, 4 packets in cycle 1 and 4 in cycle 2 -> DONE after cycle 2, total=8.
REQ-034 SHALL verify: port 2 delivers 3 packets with address field 1 -> misroute=3, port_count[2]=3.
REQ-035 SHALL verify: valid high with ready low for 10 cycles -> counts remain 0 and busy=1.
REQ-036 SHALL verify: CountWidth=4, 20 accepted packets on port 0 -> port_count[0]=15 and overflow=1.
REQ-037 SHALL verify: i_clear mid-RUN -> next cycle IDLE with all counts 0; i_start in the same cycle as i_clear -> ignored.
